pos_swap_ctrl: RTL and testbench

Swap controller that drives the port of a single-port position memory (`pos_X`/`pos_Y` style: `read`, `write`, `i`, `dataWrite`, `dataRead`). It is the initiator side of that memory interface. On a start request it reads the positions of two nodes, writes them back exchanged, and reports the pre-swap values to the annealing cost logic. One instance sits beside each coordinate memory in the placement datapath.

---
 rtl/pos_pkg.sv | 19 +
 rtl/pos_idx_check.sv | 19 +
 rtl/pos_swap_ctrl.sv | 138 +++++++++++++
 tb/tb_pos_swap_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pos_pkg.sv
// Shared widths and state encoding for the position-memory swap controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pos_pkg;

  localparam int POS_DATA_W = 32;
  localparam int POS_IDX_W  = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_WAIT_B,
    S_WR_A,
    S_WR_B,
    S_DONE
  } pos_swap_state_t;

endpackage

// File: rtl/pos_idx_check.sv
// Range comparator: flags a request whose either index is >= n_node.
// Latency: combinational.
// Backpressure: none.
// Ports: a_idx/b_idx indices under test; bad high when either is out of range.
module pos_idx_check
  import pos_pkg::*;
#(
  parameter int n_node = 14
) (
  input  logic [POS_IDX_W-1:0] a_idx,
  input  logic [POS_IDX_W-1:0] b_idx,
  output logic                 bad
);

  localparam logic [POS_IDX_W-1:0] node_lim = n_node[POS_IDX_W-1:0];

  assign bad = (a_idx >= node_lim) || (b_idx >= node_lim);

endmodule

// File: rtl/pos_swap_ctrl.sv
// Swap controller: reads pos[a], pos[b] from a single-port memory, writes them back exchanged.
// Latency: done 6 cycles after start (4 if a==b, 1 on range error); one swap per 6-7 cycles.
// Backpressure: start is honoured only in IDLE or DONE; otherwise ignored, never queued.
// Optional feature: POS_SWAP_RANGE_CHECK_EN enables index range checking and err.
// Ports: clk/reset (async, active-high); start/a_idx/b_idx request; busy/done/err/old_a/old_b
//        status; mem_read/mem_write/mem_i/mem_wdata/mem_rdata memory initiator port.
module pos_swap_ctrl
  import pos_pkg::*;
#(
  parameter int n_node = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [POS_IDX_W-1:0]  a_idx,
  input  logic [POS_IDX_W-1:0]  b_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [POS_DATA_W-1:0] old_a,
  output logic [POS_DATA_W-1:0] old_b,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [POS_IDX_W-1:0]  mem_i,
  output logic [POS_DATA_W-1:0] mem_wdata,
  input  logic [POS_DATA_W-1:0] mem_rdata
);

  pos_swap_state_t state, state_nxt;

  logic [POS_IDX_W-1:0]  a_q, b_q;
  logic                  accept;
  logic                  idx_bad;
  logic                  err_nxt;
  logic                  rd_nxt, wr_nxt;
  logic [POS_IDX_W-1:0]  i_nxt;
  logic [POS_DATA_W-1:0] wdata_nxt;

`ifdef POS_SWAP_RANGE_CHECK_EN
  pos_idx_check #(
    .n_node (n_node)
  ) u_idx_check (
    .a_idx (a_idx),
    .b_idx (b_idx),
    .bad   (idx_bad)
  );
`else
  assign idx_bad = 1'b0;
`endif

  // Next state, then the port values that state will present. All outputs are
  // registered from these, so the memory sees them exactly in the named state.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    err_nxt   = 1'b0;
    rd_nxt    = 1'b0;
    wr_nxt    = 1'b0;
    i_nxt     = '0;
    wdata_nxt = '0;

    unique case (state)
      // DONE accepts a new request as well, giving back-to-back swaps.
      S_IDLE, S_DONE: begin
        if (start) begin
          accept    = 1'b1;
          err_nxt   = idx_bad;
          state_nxt = idx_bad ? S_DONE : S_RD_A;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_RD_A:   state_nxt = S_RD_B;
      S_RD_B:   state_nxt = S_WAIT_B;
      // Equal indices: nothing to exchange, skip both writes.
      S_WAIT_B: state_nxt = (a_q == b_q) ? S_DONE : S_WR_A;
      S_WR_A:   state_nxt = S_WR_B;
      S_WR_B:   state_nxt = S_DONE;
      default:  state_nxt = S_IDLE;
    endcase

    unique case (state_nxt)
      S_RD_A: begin
        rd_nxt = 1'b1;
        i_nxt  = a_idx;  // only reached on accept, a_q not yet loaded
      end
      S_RD_B: begin
        rd_nxt = 1'b1;
        i_nxt  = b_q;
      end
      S_WR_A: begin
        wr_nxt    = 1'b1;
        i_nxt     = a_q;
        wdata_nxt = mem_rdata;  // pos[b], being captured into old_b this same edge
      end
      S_WR_B: begin
        wr_nxt    = 1'b1;
        i_nxt     = b_q;
        wdata_nxt = old_a;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      old_a     <= '0;
      old_b     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_i     <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q <= a_idx;
        b_q <= b_idx;
      end
      // Memory read data lags the read request by one cycle.
      if (state == S_RD_B)   old_a <= mem_rdata;
      if (state == S_WAIT_B) old_b <= mem_rdata;
      busy      <= (state_nxt != S_IDLE);
      done      <= (state_nxt == S_DONE);
      err       <= err_nxt;
      mem_read  <= rd_nxt;
      mem_write <= wr_nxt;
      mem_i     <= i_nxt;
      mem_wdata <= wdata_nxt;
    end
  end

endmodule

// File: tb/tb_pos_swap_ctrl.sv
// Self-checking bench for pos_swap_ctrl with a behavioural position memory.
// Latency: n/a.
// Backpressure: n/a.
module tb_pos_swap_ctrl;

  localparam int NN = 14;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a_idx, b_idx;
  logic        busy, done, err;
  logic [31:0] old_a, old_b;
  logic        mem_read, mem_write;
  logic [31:0] mem_i, mem_wdata, mem_rdata;

  int checks = 0;
  int passes = 0;

  logic [31:0] mem     [0:NN-1];
  logic [31:0] ref_mem [0:NN-1];
  logic [31:0] last_a, last_b;

  always #5 clk = ~clk;

  pos_swap_ctrl #(.n_node(NN)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a_idx     (a_idx),
    .b_idx     (b_idx),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .old_a     (old_a),
    .old_b     (old_b),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_i     (mem_i),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [31:0] init_val(input int i);
    case (i)
      2:       return 32'h10;
      3:       return 32'h7;
      5:       return 32'h20;
      default: return 32'h100 + i;
    endcase
  endfunction

  // Attached memory: registered read data, reloads its contents on reset.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NN; i++) mem[i] <= init_val(i);
      mem_rdata <= '0;
    end else begin
      if (mem_write && mem_i < NN) mem[mem_i[3:0]] <= mem_wdata;
      if (mem_read) mem_rdata <= (mem_i < NN) ? mem[mem_i[3:0]] : 32'h0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] ref_rd(input logic [31:0] i);
    return (i < NN) ? ref_mem[i[3:0]] : 32'h0;
  endfunction

  task automatic ref_wr(input logic [31:0] i, input logic [31:0] d);
    if (i < NN) ref_mem[i[3:0]] = d;
  endtask

  task automatic ref_reload();
    for (int i = 0; i < NN; i++) ref_mem[i] = init_val(i);
    last_a = '0;
    last_b = '0;
  endtask

  // One complete request; expected data comes from the reference array.
  task automatic run_swap(input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input bit exp_err, input string tag);
    int lat, wr_cnt, rd_cnt;
    bit bad_port;
    logic [31:0] ea, eb;
    if (exp_err) begin ea = last_a; eb = last_b; end
    else begin ea = ref_rd(a); eb = ref_rd(b); end
    @(negedge clk);
    a_idx = a; b_idx = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_idx = $urandom;
    b_idx = $urandom;
    chk({tag, " busy_t1"}, {31'b0, busy}, 32'd1);
    lat = 1; wr_cnt = 0; rd_cnt = 0; bad_port = 1'b0;
    while (done !== 1'b1 && lat < 20) begin
      if (mem_read && mem_write) bad_port = 1'b1;
      if (!mem_read && !mem_write && (mem_i != 0 || mem_wdata != 0)) bad_port = 1'b1;
      if (mem_write) wr_cnt++;
      if (mem_read) rd_cnt++;
      @(negedge clk);
      lat++;
    end
    if (mem_read || mem_write || mem_i != 0 || mem_wdata != 0) bad_port = 1'b1;
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " err"}, {31'b0, err}, {31'b0, exp_err});
    chk({tag, " old_a"}, old_a, ea);
    chk({tag, " old_b"}, old_b, eb);
    chk({tag, " reads"}, rd_cnt, exp_err ? 0 : 2);
    chk({tag, " writes"}, wr_cnt, (exp_err || a == b) ? 0 : 2);
    chk({tag, " port_rules"}, {31'b0, bad_port}, 32'd0);
    if (!exp_err && a != b) begin
      ref_wr(a, eb);
      ref_wr(b, ea);
    end
    if (a < NN) chk({tag, " mem_a"}, mem[a[3:0]], ref_mem[a[3:0]]);
    if (b < NN) chk({tag, " mem_b"}, mem[b[3:0]], ref_mem[b[3:0]]);
    last_a = ea;
    last_b = eb;
    @(negedge clk);
    chk({tag, " idle_after"}, {30'b0, busy, done}, 32'd0);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    bit          err;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int n, d1, d2, ndone;
    logic [31:0] r0, r1, ra, rb;

    vecs[0] = '{a: 2,  b: 5,  lat: 6, err: 0};
    vecs[1] = '{a: 3,  b: 3,  lat: 4, err: 0};
    vecs[2] = '{a: 0,  b: 13, lat: 6, err: 0};
    vecs[3] = '{a: 13, b: 0,  lat: 6, err: 0};
    vecs[4] = '{a: 6,  b: 6,  lat: 4, err: 0};

    reset = 1'b1; start = 1'b0; a_idx = '0; b_idx = '0;
    ref_reload();
    repeat (3) @(negedge clk);
    chk("reset outputs", {busy, done, err, mem_read, mem_write}, 32'd0);
    chk("reset old_a", old_a, 32'd0);
    chk("reset old_b", old_b, 32'd0);
    chk("reset mem_i", mem_i, 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;

    for (int k = 0; k < 5; k++)
      run_swap(vecs[k].a, vecs[k].b, vecs[k].lat, vecs[k].err, $sformatf("vec%0d", k));

`ifdef POS_SWAP_RANGE_CHECK_EN
    run_swap(14, 0, 1, 1'b1, "range_a");
    run_swap(3, 32'hFFFF_FFFF, 1, 1'b1, "range_b");
`else
    run_swap(14, 0, 6, 1'b0, "oor_a");
    run_swap(3, 32'hFFFF_FFFF, 6, 1'b0, "oor_b");
`endif

    // start held for 10 cycles: second request taken only in the DONE cycle.
    r0 = ref_mem[0]; r1 = ref_mem[1];
    @(negedge clk);
    a_idx = 0; b_idx = 1; start = 1'b1;
    d1 = 0; d2 = 0; ndone = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 10) start = 1'b0;
      if (done) begin
        ndone++;
        if (ndone == 1) d1 = c;
        else if (ndone == 2) d2 = c;
      end
      if (c > 10 && !busy) break;
    end
    chk("held done_count", ndone, 2);
    chk("held done1_cycle", d1, 6);
    chk("held done2_cycle", d2, 12);
    chk("held old_a", old_a, r1);
    chk("held old_b", old_b, r0);
    chk("held mem0", mem[0], r0);
    chk("held mem1", mem[1], r1);
    last_a = r1; last_b = r0;

    // Reset asserted during WR_A.
    @(negedge clk);
    a_idx = 0; b_idx = 1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!mem_write && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst wr_a cycle", n, 4);
    reset = 1'b1;
    #1;
    chk("rst async flags", {busy, done, err, mem_read, mem_write}, 32'd0);
    chk("rst async mem_i", mem_i, 32'd0);
    chk("rst async wdata", mem_wdata, 32'd0);
    chk("rst async old_a", old_a, 32'd0);
    chk("rst async old_b", old_b, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ref_reload();
    run_swap(0, 1, 6, 1'b0, "post_reset");

    for (int k = 0; k < 30; k++) begin
      ra = $urandom_range(0, NN - 1);
      rb = ($urandom_range(0, 3) == 0) ? ra : 32'($urandom_range(0, NN - 1));
      run_swap(ra, rb, (ra == rb) ? 4 : 6, 1'b0, $sformatf("rand%0d", k));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", passes, checks);
    $fatal(1);
  end

endmodule
